// File: rtl/fp_32_oprand_feeder.sv
// Operand feeder for an FP32 reduction tree.
// Collects up to OP_NUM words from a valid/ready stream. A group ends on the
// last slot or on in_last. The group is issued to the tree and the returned
// sum is held until downstream takes it. Operand values are never inspected:
// unused slots stay zero, which the tree adds as +0.
module fp_32_oprand_feeder #(
   parameter int WIDTH    = 32,
   parameter int OP_NUM   = 32,
   parameter int WAIT_MAX = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_valid,
   input  logic                      in_last,
   output logic                      in_ready,
   output logic [OP_NUM*WIDTH-1:0]   oprands_out,
   output logic                      tree_valid,
   output logic                      tree_en,
   input  logic [WIDTH-1:0]          tree_result,
   input  logic                      tree_done,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      err
);

   localparam int CW = $clog2(OP_NUM) + 1;

   localparam logic [1:0] S_FILL  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   // Last watchdog value of a WAIT window; WAIT lasts WAIT_MAX cycles at most.
   localparam logic [5:0]    WD_LAST  = 6'(WAIT_MAX - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OP_NUM - 1);

   logic [1:0]                    r_state;
   logic [CW-1:0]                 r_cnt;
   logic [OP_NUM-1:0][WIDTH-1:0]  r_buf;
   logic [5:0]                    r_wdog;
   logic [WIDTH-1:0]              r_out_data;
   logic                          r_out_valid;
   logic                          r_err;

   logic w_acc;
   logic w_grp_end;
   logic w_done;
   logic w_tmo;
   logic w_release;
   logic w_clr;

   assign w_acc     = in_valid & (r_state == S_FILL);
   assign w_grp_end = w_acc & (in_last | (r_cnt == CNT_LAST));
   // tree_done only counts inside WAIT; stray strobes elsewhere are dropped.
   assign w_done    = (r_state == S_WAIT) & tree_done;
   assign w_tmo     = (r_state == S_WAIT) & ~tree_done & (r_wdog == WD_LAST);
   // out_valid is always high in HOLD, so out_ready alone completes the handshake.
   assign w_release = (r_state == S_HOLD) & out_ready;
   // Both ways back to FILL empty the group.
   assign w_clr     = w_tmo | w_release;

   // State sequencing: FILL -> ISSUE -> WAIT -> HOLD -> FILL, or WAIT -> FILL on timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FILL;
      end else begin
         case (r_state)
            S_FILL:  if (w_grp_end) r_state <= S_ISSUE;
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT:  if (w_done) r_state <= S_HOLD;
                     else if (w_tmo) r_state <= S_FILL;
            S_HOLD:  if (w_release) r_state <= S_FILL;
            default: r_state <= S_FILL;
         endcase
      end
   end

   // Write pointer: counts accepted words and rewinds when the group is emptied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_cnt <= '0;
      else if (w_clr) r_cnt <= '0;
      else if (w_acc) r_cnt <= r_cnt + 1'b1;
   end

   // Operand slots: written only on accepted words and zeroed on clear,
   // so the tree sees a frozen buffer from ISSUE through HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf <= '0;
      end else if (w_clr) begin
         r_buf <= '0;
      end else if (w_acc) begin
         for (int k = 0; k < OP_NUM; k++)
            if (r_cnt == CW'(k)) r_buf[k] <= in_data;
      end
   end

   // Watchdog: zeroed in ISSUE, counts every WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_wdog <= '0;
      else if (r_state == S_ISSUE) r_wdog <= '0;
      else if (r_state == S_WAIT)  r_wdog <= r_wdog + 1'b1;
   end

   // Result capture and hold until downstream accepts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else if (w_done) begin
         r_out_data  <= tree_result;
         r_out_valid <= 1'b1;
      end else if (w_release) begin
         r_out_valid <= 1'b0;
      end
   end

   // Sticky timeout flag; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
   end

   assign in_ready    = (r_state == S_FILL);
   assign busy        = (r_state != S_FILL);
   assign tree_valid  = (r_state == S_ISSUE);
   assign tree_en     = (r_state == S_ISSUE) | (r_state == S_WAIT);
   assign oprands_out = r_buf;
   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign err         = r_err;

endmodule

// File: tb/tb_fp_32_oprand_feeder.sv
// Directed bench for fp_32_oprand_feeder with an 11-cycle tree model.
module tb_fp_32_oprand_feeder;

   localparam int W = 32;
   localparam int N = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_last = 1'b0;
   logic           in_ready;
   logic [N*W-1:0] oprands_out;
   logic           tree_valid;
   logic           tree_en;
   logic [W-1:0]   tree_result = '0;
   logic           tree_done = 1'b0;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           busy;
   logic           err;

   int n_vec = 0;
   int n_bad = 0;
   int tm_cnt = 0;
   bit tm_en = 1'b1;
   bit tm_force = 1'b0;
   int tv_cnt = 0;
   int ov_cnt = 0;

   fp_32_oprand_feeder #(.WIDTH(W), .OP_NUM(N), .WAIT_MAX(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .oprands_out(oprands_out), .tree_valid(tree_valid), .tree_en(tree_en),
      .tree_result(tree_result), .tree_done(tree_done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Tree sum for the operand patterns used here (counts of 1.0).
   function automatic logic [W-1:0] tree_sum(input logic [N*W-1:0] ops);
      int c = 0;
      for (int k = 0; k < N; k++) if (ops[k*W +: W] == 32'h3F800000) c++;
      case (c)
         1:  return 32'h3F800000;
         2:  return 32'h40000000;
         3:  return 32'h40400000;
         32: return 32'h42000000;
         default: return 32'h00000000;
      endcase
   endfunction

   // Tree model: done 11 cycles after the tree_valid cycle; plus monitors.
   always @(negedge clk) begin
      tree_done = 1'b0;
      if (!rst_n) tm_cnt = 0;
      else begin
         if (tm_cnt != 0) begin
            tm_cnt--;
            if (tm_cnt == 0 && tm_en) begin
               tree_done = 1'b1;
               tree_result = tree_sum(oprands_out);
            end
         end
         if (tree_valid) tm_cnt = 11;
      end
      if (tm_force) begin
         tree_done = 1'b1;
         tree_result = 32'hDEADBEEF;
      end
      if (tree_valid) tv_cnt++;
      if (out_valid) ov_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] d, input logic last);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = d; in_last = last;
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Cycles from the last transfer cycle until out_valid is seen.
   task automatic wait_ov(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 40);
   endtask

   task automatic release_out();
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      chk("rel_ov", out_valid, 0);
      chk("rel_rdy", in_ready, 1);
      chk("rel_clr", oprands_out == '0, 1);
   endtask

   task automatic group32(input string tag);
      int n;
      int tv0;
      tv0 = tv_cnt;
      for (int i = 0; i < N; i++) send(32'h3F800000, 1'b0);
      idle();
      wait_ov(n);
      chk({tag, "_lat"}, n, 13);
      chk({tag, "_sum"}, out_data, 32'h42000000);
      chk({tag, "_tv"}, tv_cnt - tv0, 1);
      chk({tag, "_s31"}, oprands_out[31*W +: W], 32'h3F800000);
   endtask

   initial begin
      int n, wc, ov0;
      // reset state
      #12;
      chk("rst_rdy", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_te", tree_en, 0);
      chk("rst_tv", tree_valid, 0);
      chk("rst_ops", oprands_out == '0, 1);
      @(negedge clk); rst_n = 1'b1;

      // full 32-word group; check strobe timing on the way
      for (int i = 0; i < N; i++) send(32'h3F800000, 1'b0);
      idle();
      @(negedge clk);
      chk("iss_tv", tree_valid, 1);
      chk("iss_te", tree_en, 1);
      chk("iss_rdy", in_ready, 0);
      @(negedge clk);
      chk("wait_tv", tree_valid, 0);
      chk("wait_te", tree_en, 1);
      n = 2;
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      chk("g32_lat", n, 13);
      chk("g32_sum", out_data, 32'h42000000);
      chk("hold_te", tree_en, 0);
      chk("hold_busy", busy, 1);
      release_out();

      // partial group of 3
      send(32'h3F800000, 1'b0);
      send(32'h3F800000, 1'b0);
      send(32'h3F800000, 1'b1);
      idle();
      wait_ov(n);
      chk("g3_lat", n, 13);
      chk("g3_sum", out_data, 32'h40400000);
      chk("g3_s2", oprands_out[2*W +: W], 32'h3F800000);
      chk("g3_hi0", oprands_out[N*W-1:3*W] == '0, 1);
      release_out();

      // one-word group, then backpressure in HOLD with in_valid held high
      send(32'h3F800000, 1'b1);
      idle();
      wait_ov(n);
      chk("g1_lat", n, 13);
      in_valid = 1'b1; in_data = 32'h40000000; in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rdy", in_ready, 0);
         chk("bp_ov", out_valid, 1);
         chk("bp_data", out_data, 32'h3F800000);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      chk("bp_rel_rdy", in_ready, 1);
      chk("bp_rel_ov", out_valid, 0);
      chk("bp_rel_s0", oprands_out[0 +: W], 32'h0);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp_new_s0", oprands_out[0 +: W], 32'h40000000);
      chk("bp_new_busy", busy, 0);

      // watchdog: tree never answers (group already holds one word)
      tm_en = 1'b0;
      ov0 = ov_cnt;
      send(32'h3F800000, 1'b1);
      idle();
      wc = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tree_en && !tree_valid) wc++;
         if (in_ready && wc > 0) break;
      end
      chk("wd_cycles", wc, 16);
      chk("wd_err", err, 1);
      chk("wd_rdy", in_ready, 1);
      chk("wd_noov", ov_cnt - ov0, 0);
      chk("wd_clr", oprands_out == '0, 1);
      repeat (3) @(negedge clk);
      chk("wd_sticky", err, 1);
      tm_en = 1'b1;

      // reset five cycles into WAIT, then a stray tree_done
      for (int i = 0; i < N; i++) send(32'h3F800000, 1'b0);
      idle();
      wc = 0;
      for (int i = 0; i < 40 && wc < 5; i++) begin
         @(negedge clk);
         if (tree_en && !tree_valid) wc++;
      end
      chk("mr_inwait", wc, 5);
      rst_n = 1'b0;
      ov0 = ov_cnt;
      #1;
      chk("mr_err", err, 0);
      chk("mr_busy", busy, 0);
      chk("mr_te", tree_en, 0);
      chk("mr_tv", tree_valid, 0);
      chk("mr_ov", out_valid, 0);
      chk("mr_od", out_data, 0);
      chk("mr_ops", oprands_out == '0, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("mr_rdy", in_ready, 1);
      @(posedge clk); #1 tm_force = 1'b1;
      @(posedge clk); #1 tm_force = 1'b0;
      repeat (14) @(negedge clk);
      chk("mr_noov", ov_cnt - ov0, 0);
      chk("mr_od2", out_data, 0);
      chk("mr_idle", busy, 0);
      group32("post");
      release_out();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
